// File: rtl/bsync_trigger_arm_if.sv
// bsync_trigger_arm_if: bsync supervision, arm control and trigger status bundle
interface bsync_trigger_arm_if #(
    parameter int COUNT_WIDTH = 8,
    parameter int DELAY_WIDTH = 16,
    parameter int WIDTH_WIDTH = 8
);
    logic                   bsync;
    logic                   bsync_ready;
    logic                   bsync_alignment_error;
    logic                   arm;
    logic                   disarm;
    logic [COUNT_WIDTH-1:0] edge_count;
    logic [DELAY_WIDTH-1:0] trig_delay;
    logic [WIDTH_WIDTH-1:0] trig_width;
    logic                   trigger;
    logic                   armed;
    logic                   done;
    logic                   error;
    logic [COUNT_WIDTH-1:0] edge_seen;
    logic [2:0]             state;
    modport master (
        output bsync, bsync_ready, bsync_alignment_error, arm, disarm,
               edge_count, trig_delay, trig_width,
        input  trigger, armed, done, error, edge_seen, state
    );
    modport slave (
        input  bsync, bsync_ready, bsync_alignment_error, arm, disarm,
               edge_count, trig_delay, trig_width,
        output trigger, armed, done, error, edge_seen, state
    );
endinterface

// File: rtl/bsync_trigger_arm.sv
// bsync_trigger_arm: counts bsync edges after arm, waits a delay, then fires one trigger pulse
module bsync_trigger_arm #(
    parameter int COUNT_WIDTH = 8,
    parameter int DELAY_WIDTH = 16,
    parameter int WIDTH_WIDTH = 8
) (
    input logic clk,
    input logic rstn,
    bsync_trigger_arm_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        DELAY = 3'd2,
        PULSE = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;
    state_t cur, nxt;
    logic bsync_q, trig_q, done_q, error_q;
    logic [COUNT_WIDTH-1:0] seen_q, tgt_q;
    logic [DELAY_WIDTH-1:0] dly_q, dcnt_q;
    logic [WIDTH_WIDTH-1:0] wid_q, pcnt_q;
    logic rise, bad, hit, accept, active_nxt;
    assign rise       = bus.bsync & ~bsync_q;
    assign bad        = ~bus.bsync_ready | bus.bsync_alignment_error;
    assign hit        = rise && (seen_q == tgt_q - COUNT_WIDTH'(1));
    assign accept     = (cur == IDLE || cur == DONE) && nxt == ARMED;
    assign active_nxt = nxt == ARMED || nxt == DELAY || nxt == PULSE;
    // State register
    always_ff @(posedge clk) begin
        cur <= !rstn ? IDLE : nxt;
    end
    // Next state: disarm overrides everything, then supervision errors, then arm, then counting
    always_comb begin
        nxt = IDLE;
        case (cur)
            IDLE, DONE: nxt = !bus.arm ? cur : bus.bsync_alignment_error ? ERROR : bus.bsync_ready ? ARMED : cur;
            ARMED:      nxt = bad ? ERROR : !hit ? ARMED : (dly_q == '0) ? PULSE : DELAY;
            DELAY:      nxt = bad ? ERROR : (dcnt_q <= DELAY_WIDTH'(1)) ? PULSE : DELAY;
            PULSE:      nxt = bad ? ERROR : (pcnt_q == '0) ? DONE : PULSE;
            ERROR:      nxt = ERROR;
            default:    nxt = IDLE;
        endcase
        if (bus.disarm) nxt = IDLE;
    end
    // Outputs: armed/state decode from the current state, the rest come from registers
    always_comb begin
        bus.armed     = cur == ARMED || cur == DELAY || cur == PULSE;
        bus.state     = cur;
        bus.trigger   = trig_q;
        bus.done      = done_q;
        bus.error     = error_q;
        bus.edge_seen = seen_q;
    end
    // Datapath: edge detect, latched settings, delay/pulse counters and sticky flags
    always_ff @(posedge clk) begin
        if (!rstn) begin
            bsync_q <= 1'b0;
            trig_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            seen_q  <= '0;
            tgt_q   <= '0;
            dly_q   <= '0;
            wid_q   <= '0;
            dcnt_q  <= '0;
            pcnt_q  <= '0;
        end else begin
            bsync_q <= bus.bsync;
            trig_q  <= cur == PULSE && nxt == PULSE && pcnt_q != '0;
            if (accept) begin
                tgt_q  <= (bus.edge_count == '0) ? COUNT_WIDTH'(1) : bus.edge_count;
                dly_q  <= bus.trig_delay;
                wid_q  <= (bus.trig_width == '0) ? WIDTH_WIDTH'(1) : bus.trig_width;
                seen_q <= '0;
            end else if (cur == ARMED && rise && active_nxt) begin
                seen_q <= seen_q + COUNT_WIDTH'(1);
            end
            if (cur == ARMED && nxt == DELAY) dcnt_q <= dly_q;
            else if (cur == DELAY && dcnt_q != '0) dcnt_q <= dcnt_q - DELAY_WIDTH'(1);
            if (cur != PULSE && nxt == PULSE) pcnt_q <= wid_q;
            else if (cur == PULSE && pcnt_q != '0) pcnt_q <= pcnt_q - WIDTH_WIDTH'(1);
            if (accept || bus.disarm) done_q <= 1'b0;
            else if (cur == PULSE && nxt == DONE) done_q <= 1'b1;
            if (bus.disarm) error_q <= 1'b0;
            else if (nxt == ERROR) error_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bsync_trigger_arm.sv
// tb_bsync_trigger_arm: directed plus random stimulus against a timeline model of the trigger arm
module tb_bsync_trigger_arm;
    localparam int MS_IDLE = 0, MS_ARMED = 1, MS_SCHED = 2, MS_DONE = 3, MS_ERR = 4;
    logic clk = 1'b0, rstn = 1'b0;
    int nchk = 0, nerr = 0;
    int cyc = 0, ph = 0, per = 16, hi = 8;
    int trig_cnt = 0, trig_first = -1, acc = 0;
    bit chk_en = 0;
    int rq[$];
    int mm = MS_IDLE, mt = 1, mdl = 0, mw = 1, ms = 0, md = 0, me = 0, mE = 0, pb = 0;
    bsync_trigger_arm_if bus ();
    bsync_trigger_arm dut (.clk(clk), .rstn(rstn), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #2;
        bus.arm = 1'b0;
        bus.disarm = 1'b0;
        ph++;
        bus.bsync = (ph % per) < hi;
    endtask
    task automatic mark();
        trig_cnt = 0;
        trig_first = -1;
    endtask
    task automatic wait_state(input int s, input int budget);
        int n = 0;
        while (int'(bus.state) != s && n < budget) begin
            step();
            n++;
        end
        chk($sformatf("wait_state_%0d", s), int'(bus.state), s);
    endtask
    // Reference model: tracks arming, edge count, and the absolute cycle of the final edge;
    // trigger window and reported state are derived from that timeline arithmetically.
    always @(posedge clk) begin
        int r;
        cyc++;
        r = (bus.bsync && pb == 0) ? 1 : 0;
        pb = rstn ? int'(bus.bsync) : 0;
        if (r == 1) rq.push_back(cyc);
        if (!rstn) begin
            mm = MS_IDLE; ms = 0; md = 0; me = 0;
        end else if (bus.disarm) begin
            mm = MS_IDLE; md = 0; me = 0;
        end else begin
            bit bad;
            bad = !bus.bsync_ready || bus.bsync_alignment_error;
            if (mm == MS_ARMED || mm == MS_SCHED) begin
                if (bad) begin
                    mm = MS_ERR; me = 1;
                end else if (mm == MS_ARMED && r == 1) begin
                    ms++;
                    if (ms == mt) begin mE = cyc; mm = MS_SCHED; end
                end else if (mm == MS_SCHED && cyc == mE + mdl + mw + 1) begin
                    mm = MS_DONE; md = 1;
                end
            end else if ((mm == MS_IDLE || mm == MS_DONE) && bus.arm) begin
                if (bus.bsync_alignment_error) begin
                    mm = MS_ERR; me = 1;
                end else if (bus.bsync_ready) begin
                    mm = MS_ARMED; ms = 0; md = 0;
                    mt = bus.edge_count == 0 ? 1 : int'(bus.edge_count);
                    mdl = int'(bus.trig_delay);
                    mw = bus.trig_width == 0 ? 1 : int'(bus.trig_width);
                end
            end
        end
    end
    // Every-cycle comparison of all outputs against the model, plus trigger bookkeeping
    always @(negedge clk) begin
        if (chk_en) begin
            int et, es;
            et = (mm == MS_SCHED && cyc >= mE + mdl + 1 && cyc <= mE + mdl + mw) ? 1 : 0;
            es = mm == MS_IDLE ? 0 : mm == MS_ARMED ? 1 :
                 mm == MS_SCHED ? (cyc < mE + mdl ? 2 : 3) : mm == MS_DONE ? 4 : 5;
            chk("trigger", int'(bus.trigger), et);
            chk("armed", int'(bus.armed), (mm == MS_ARMED || mm == MS_SCHED) ? 1 : 0);
            chk("done", int'(bus.done), md);
            chk("error", int'(bus.error), me);
            chk("edge_seen", int'(bus.edge_seen), ms);
            chk("state", int'(bus.state), es);
        end
        if (bus.trigger) begin
            trig_cnt++;
            if (trig_first < 0) trig_first = cyc;
        end
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end
    initial begin
        bus.bsync = 1'b0; bus.bsync_ready = 1'b1; bus.bsync_alignment_error = 1'b0;
        bus.arm = 1'b0; bus.disarm = 1'b0;
        bus.edge_count = '0; bus.trig_delay = '0; bus.trig_width = '0;
        step(); step();
        chk_en = 1;
        step();
        chk("rst_state", int'(bus.state), 0);
        chk("rst_trigger", int'(bus.trigger), 0);
        chk("rst_edge_seen", int'(bus.edge_seen), 0);
        rstn = 1'b1;
        step();
        // 3 edges, delay 5, width 4
        bus.edge_count = 8'd3; bus.trig_delay = 16'd5; bus.trig_width = 8'd4; bus.arm = 1'b1;
        step();
        rq.delete(); mark();
        wait_state(4, 200);
        chk("t1_done", int'(bus.done), 1);
        chk("t1_edge_seen", int'(bus.edge_seen), 3);
        chk("t1_width", trig_cnt, 4);
        chk("t1_gap", rq.size() >= 3 ? trig_first - rq[2] : -1, 6);
        // zero settings behave as 1/0/1, re-arm from DONE clears done
        bus.edge_count = '0; bus.trig_delay = '0; bus.trig_width = '0; bus.arm = 1'b1;
        step();
        rq.delete(); mark();
        chk("t2_done_clr", int'(bus.done), 0);
        chk("t2_armed_state", int'(bus.state), 1);
        wait_state(4, 100);
        chk("t2_width", trig_cnt, 1);
        chk("t2_gap", rq.size() >= 1 ? trig_first - rq[0] : -1, 1);
        chk("t2_edge_seen", int'(bus.edge_seen), 1);
        // arm without ready is ignored; arm with alignment error goes to ERROR
        bus.disarm = 1'b1;
        step();
        bus.bsync_ready = 1'b0; bus.arm = 1'b1;
        mark();
        repeat (160) step();
        chk("t3_idle", int'(bus.state), 0);
        chk("t3_armed", int'(bus.armed), 0);
        chk("t3_no_trig", trig_cnt, 0);
        bus.bsync_ready = 1'b1; bus.bsync_alignment_error = 1'b1; bus.arm = 1'b1;
        step();
        chk("t3_err_state", int'(bus.state), 5);
        chk("t3_err_flag", int'(bus.error), 1);
        bus.disarm = 1'b1; bus.bsync_alignment_error = 1'b0;
        step();
        chk("t3_disarm_state", int'(bus.state), 0);
        // alignment error during DELAY aborts with no trigger
        bus.edge_count = 8'd2; bus.trig_delay = 16'd20; bus.trig_width = 8'd4; bus.arm = 1'b1;
        step();
        mark();
        wait_state(2, 100);
        repeat (3) step();
        bus.bsync_alignment_error = 1'b1;
        step();
        chk("t4_err_state", int'(bus.state), 5);
        chk("t4_err_flag", int'(bus.error), 1);
        bus.bsync_alignment_error = 1'b0;
        repeat (30) step();
        chk("t4_no_trig", trig_cnt, 0);
        bus.disarm = 1'b1;
        step();
        chk("t4_cleared", int'(bus.error), 0);
        // arm+disarm together, then disarm mid-pulse
        bus.arm = 1'b1; bus.disarm = 1'b1;
        step();
        chk("t5_same_cycle", int'(bus.state), 0);
        bus.edge_count = 8'd1; bus.trig_delay = '0; bus.trig_width = 8'd10; bus.arm = 1'b1;
        step();
        wait_state(3, 100);
        mark();
        repeat (3) step();
        bus.disarm = 1'b1;
        step();
        chk("t5_trig_low", int'(bus.trigger), 0);
        chk("t5_done", int'(bus.done), 0);
        chk("t5_partial", trig_cnt, 3);
        // reset mid-pulse, then a rise coincident with arm is not counted
        bus.arm = 1'b1;
        step();
        wait_state(3, 100);
        repeat (2) step();
        rstn = 1'b0;
        step();
        chk("t6_rst_trig", int'(bus.trigger), 0);
        chk("t6_rst_armed", int'(bus.armed), 0);
        chk("t6_rst_state", int'(bus.state), 0);
        rstn = 1'b1;
        for (int n = 0; n < 40 && (ph % per) != 0; n++) step();
        bus.edge_count = 8'd1; bus.trig_delay = '0; bus.trig_width = 8'd2; bus.arm = 1'b1;
        step();
        acc = cyc; rq.delete(); mark();
        wait_state(4, 100);
        chk("t6_edge_seen", int'(bus.edge_seen), 1);
        chk("t6_next_rise", rq.size() >= 1 ? rq[0] - acc : -1, 16);
        chk("t6_gap", rq.size() >= 1 ? trig_first - rq[0] : -1, 1);
        chk("t6_width", trig_cnt, 2);
        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step();
            if (i % 500 == 0) begin
                per = $urandom_range(3, 20);
                hi = per / 2;
            end
            bus.arm = $urandom_range(0, 9) == 0;
            bus.disarm = $urandom_range(0, 59) == 0;
            bus.bsync_ready = $urandom_range(0, 199) != 0;
            bus.bsync_alignment_error = $urandom_range(0, 299) == 0;
            rstn = $urandom_range(0, 499) != 0;
            bus.edge_count = 8'($urandom_range(0, 3));
            bus.trig_delay = 16'($urandom_range(0, 12));
            bus.trig_width = 8'($urandom_range(0, 6));
        end
        step();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
